// File: rtl/serializer_nto1_lanes.sv
// N:1 multi-lane serializer: parallel words in, one bit per lane per clock out.
// A one-word holding register decouples the producer; IDLE_WORD fills gaps.

module serializer_nto1_lane #(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_bit
);
  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (i_load)
      sr_d = i_word;
    else if (i_shift)
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sr_q <= '0;
    else          sr_q <= sr_d;
  end

  assign o_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
endmodule

module serializer_nto1_lanes #(
  parameter int               WIDTH     = 10,
  parameter int               LANES     = 3,
  parameter bit               MSB_FIRST = 1'b0,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(10'b1101010100)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [LANES*WIDTH-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_slip,
  output logic [LANES-1:0]   o_data,
  output logic               o_word_start,
  output logic               o_underrun
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           full_q, full_d;
  logic [LANES-1:0][WIDTH-1:0]    hold_q, hold_d;
  logic [LANES-1:0][WIDTH-1:0]    din, load_word;
  logic                           load, shift, accept, bypass;
  logic                           word_start_q, underrun_q;

  assign din    = i_data;
  assign load   = (cnt_q == LAST) && !i_slip;
  assign shift  = !i_slip && !load;
  assign o_ready = !full_q || load;
  assign accept = i_valid && o_ready;
  // An empty holder at a load hands the incoming word straight to the lanes.
  assign bypass = load && !full_q && i_valid;

  always_comb begin
    load_word = {LANES{IDLE_WORD}};
    if (full_q)       load_word = hold_q;
    else if (i_valid) load_word = din;
  end

  always_comb begin
    cnt_d  = cnt_q;
    full_d = full_q;
    hold_d = hold_q;
    if (load)       cnt_d = '0;
    else if (shift) cnt_d = cnt_q + CW'(1);
    if (accept && !bypass) begin
      hold_d = din;
      full_d = 1'b1;
    end else if (load && full_q) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q        <= '0;
      full_q       <= 1'b0;
      hold_q       <= '0;
      word_start_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      hold_q       <= hold_d;
      word_start_q <= load;
      underrun_q   <= load && !full_q && !i_valid;
    end
  end

  assign o_word_start = word_start_q;
  assign o_underrun   = underrun_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    serializer_nto1_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (load),
      .i_shift (shift),
      .i_word  (load_word[k]),
      .o_bit   (o_data[k])
    );
  end
endmodule

// File: tb/tb_serializer_nto1_lanes.sv
// Randomized + directed bench for serializer_nto1_lanes against a word/bit-index
// reference model; an LSB-first and an MSB-first instance run side by side.

module tb_serializer_nto1_lanes;
  localparam int W  = 10;
  localparam int L  = 3;
  localparam int LW = W * L;
  localparam logic [W-1:0] IDLE = 10'b1101010100;

  logic          i_clk = 1'b0;
  logic          i_rst_n, i_valid, i_slip;
  logic [LW-1:0] i_data;
  logic          o_ready, o_ws, o_ur, m_ready, m_ws, m_ur;
  logic [L-1:0]  o_data, m_data;

  always #5 i_clk = ~i_clk;

  serializer_nto1_lanes #(.WIDTH(W), .LANES(L), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_slip(i_slip), .o_data(o_data),
    .o_word_start(o_ws), .o_underrun(o_ur));

  serializer_nto1_lanes #(.WIDTH(W), .LANES(L), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(m_ready), .i_slip(i_slip), .o_data(m_data),
    .o_word_start(m_ws), .o_underrun(m_ur));

  // Reference: the word currently on the wire, the index of the bit showing,
  // and a FIFO of at most one accepted-but-not-started word.
  int            idx;
  logic [LW-1:0] cur;
  logic [LW-1:0] q[$];
  logic          exp_ws, exp_ur;
  int            ntot = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    ntot++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  function automatic logic [L-1:0] exp_bits(input bit msb);
    logic [L-1:0] b;
    for (int k = 0; k < L; k++) b[k] = cur[k*W + (msb ? W-1-idx : idx)];
    return b;
  endfunction

  function automatic logic [LW-1:0] rnd();
    return LW'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    idx = 0; cur = '0; q.delete(); exp_ws = 1'b0; exp_ur = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  32'(o_data), 32'd0);
    chk({tag, "_mdata"}, 32'(m_data), 32'd0);
    chk({tag, "_ws"},    32'(o_ws | m_ws), 32'd0);
    chk({tag, "_ur"},    32'(o_ur | m_ur), 32'd0);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
  endtask

  task automatic step(input logic v, input logic s, input logic [LW-1:0] d);
    logic rdy;
    i_valid = v; i_slip = s; i_data = d;
    #1;
    rdy = (q.size() == 0) || (idx == W-1 && !s);
    chk("ready",  32'(o_ready), 32'(rdy));
    chk("mready", 32'(m_ready), 32'(rdy));
    @(posedge i_clk);
    exp_ws = 1'b0; exp_ur = 1'b0;
    if (!s && idx == W-1) begin
      exp_ws = 1'b1;
      idx    = 0;
      if (q.size() > 0) begin
        cur = q.pop_front();
        if (v) q.push_back(d);
      end else if (v) begin
        cur = d;
      end else begin
        cur    = {L{IDLE}};
        exp_ur = 1'b1;
      end
    end else begin
      if (!s) idx++;
      if (v && rdy) q.push_back(d);
    end
    #1;
    chk("data",  32'(o_data), 32'(exp_bits(1'b0)));
    chk("mdata", 32'(m_data), 32'(exp_bits(1'b1)));
    chk("ws",    32'(o_ws),   32'(exp_ws));
    chk("mws",   32'(m_ws),   32'(exp_ws));
    chk("ur",    32'(o_ur),   32'(exp_ur));
    chk("mur",   32'(m_ur),   32'(exp_ur));
  endtask

  initial begin
    int n;
    i_rst_n = 1'b0; i_valid = 1'b0; i_slip = 1'b0; i_data = '0;
    model_reset();
    #2 chk_reset_outputs("rst0");
    #20;
    @(negedge i_clk) i_rst_n = 1'b1;

    // Idle pattern after reset, underrun every word.
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, rnd());

    // Continuous valid with fixed lane words: no gaps, no underruns.
    for (int i = 0; i < 35; i++) step(1'b1, 1'b0, {10'h155, 10'h000, 10'h3FF});

    // Randomized traffic with occasional slips.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), rnd());

    // Drain, then bypass a single word whose lane0 has only the MSB set.
    n = 0;
    while (!(idx == W-1 && q.size() == 0) && n < 40) begin step(1'b0, 1'b0, rnd()); n++; end
    chk("sync_bypass", 32'(n < 40), 32'd1);
    step(1'b1, 1'b0, {20'h0, 10'h200});
    chk("bypass_no_ur", 32'(o_ur), 32'd0);
    for (int i = 0; i < W-1; i++) step(1'b0, 1'b0, rnd());

    // Fill the holder, then accept again on the load cycle: holder stays full.
    step(1'b1, 1'b0, rnd());
    n = 0;
    while (idx != W-1 && n < 20) begin step(1'b0, 1'b0, rnd()); n++; end
    chk("sync_full_load", 32'(n < 20), 32'd1);
    step(1'b1, 1'b0, rnd());
    for (int i = 0; i < 2*W + 2; i++) step(1'b0, 1'b0, rnd());

    // Single-cycle slip at bit index 4 stretches the word by one cycle.
    step(1'b1, 1'b0, rnd());
    n = 0;
    while (idx != 4 && n < 20) begin step(1'b0, 1'b0, rnd()); n++; end
    chk("sync_slip", 32'(n < 20), 32'd1);
    step(1'b0, 1'b1, rnd());
    for (int i = 0; i < W + 3; i++) step(1'b0, 1'b0, rnd());

    // Asynchronous reset mid-word with a word held; it must never appear.
    n = 0;
    while (!(idx == 6 && q.size() > 0) && n < 40) begin step(1'b1, 1'b0, rnd()); n++; end
    chk("sync_rst", 32'(n < 40), 32'd1);
    #2 i_rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    model_reset();
    i_valid = 1'b0;
    @(negedge i_clk) i_rst_n = 1'b1;
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, rnd());

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end
endmodule

// File: doc/serializer_nto1_lanes.md
SERIALIZER_NTO1_LANES -- requirements
Module: serializer_nto1_lanes

Interface
REQ-001 SHALL have parameter WIDTH, default 10, bits per word per lane (legal 2..16).
REQ-002 SHALL have parameter LANES, default 3, number of parallel serial lanes (legal 1..8).
REQ-003 SHALL have parameter MSB_FIRST, default 0, 0 = bit 0 transmitted first, 1 = bit WIDTH-1 first.
REQ-004 SHALL have parameter IDLE_WORD, default 10'b1101010100, WIDTH-bit word sent on every lane when no data available.
REQ-005 SHALL have port i_clk  input  1  bit clock; one serial bit per lane per rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 SHALL have port i_data  input  LANES*WIDTH  parallel words; lane k = i_data[k*WIDTH +: WIDTH].
REQ-008 SHALL have port i_valid  input  1  i_data holds a word for all lanes.
REQ-009 SHALL have port o_ready  output  1  block accepts i_data this cycle.
REQ-010 SHALL have port i_slip  input  1  stall: repeat the current bit for one extra cycle (word alignment).
REQ-011 SHALL have port o_data  output  LANES  serial bit per lane.
REQ-012 SHALL have port o_word_start  output  1  high while first bit of a word is on o_data.
REQ-013 SHALL have port o_underrun  output  1  one-cycle pulse, high with o_word_start when IDLE_WORD was loaded.

Function
REQ-014 SHALL keep a bit counter cnt (0..WIDTH-1), a per-lane WIDTH-bit shift register, and a one-word holding register with full flag.
REQ-015 SHALL define load = (cnt == WIDTH-1) && !i_slip.
REQ-016 SHALL, when i_slip is high, hold cnt and all shift registers unchanged that cycle; o_data repeats the previous bit; o_word_start and o_underrun are 0 that cycle.
REQ-017 SHALL, when !i_slip and !load, increment cnt and shift each lane by one toward the output end (right if MSB_FIRST=0, left if 1).
REQ-018 SHALL, on load, set cnt to 0 and load each shift register from: holding register if full; else i_data if i_valid (bypass); else IDLE_WORD.
REQ-019 SHALL drive o_data[k] from shift register bit 0 (MSB_FIRST=0) or bit WIDTH-1 (MSB_FIRST=1), directly from a register.
REQ-020 SHALL register o_word_start high for exactly the cycle after each load; o_underrun likewise when the load used IDLE_WORD.
REQ-021 SHALL drive o_ready = !full || load (combinational from state and i_slip).
REQ-022 SHALL, on i_valid && o_ready: write i_data into holding register unless consumed by bypass (REQ-018); holding register write and drain in the same load cycle leaves full=1 with new word.
REQ-023 SHALL clear full on a load that drains the holding register with no simultaneous accept.
REQ-024 SHALL, with continuous i_valid and no i_slip, transmit back-to-back words with no gap and no underrun after the first load.
REQ-025 SHALL give latency from accept (hold empty, non-load cycle) to first bit on o_data of (WIDTH-1-cnt)+1 cycles; bypass accept gives 1 cycle.
REQ-026 SHALL ignore i_data when i_valid is low; i_data need not be stable after accept.

Reset
REQ-027 SHALL, while i_rst_n is low, force cnt=0, all shift registers=0, full=0, o_data=0, o_word_start=0, o_underrun=0.
REQ-028 SHALL perform the first load on the WIDTH-th rising edge after i_rst_n deasserts (absent i_slip), so o_data is 0 for WIDTH cycles then the first word.
REQ-029 SHALL, on reset assertion mid-word, discard the word in flight and any held word; no partial word resumes after release.

Verification
REQ-030 WIDTH=10, LANES=3, reset release, i_valid=0 -> o_data=000 for 10 cycles, then each lane emits 0,0,1,0,1,0,1,0,1,1 repeating; o_underrun pulses every 10 cycles with o_word_start.
REQ-031 Continuous i_valid, lane words 10'h3FF/10'h000/10'h155 -> lane0 all 1s, lane1 all 0s, lane2 1,0,1,0... with no underrun; o_ready high once per 10 cycles while full.
REQ-032 MSB_FIRST=1, single word 10'b1000000000 on lane0 -> first bit on o_data[0] is 1, next nine 0.
REQ-033 i_slip high for 1 cycle at cnt=4 -> that bit appears 2 cycles, word spans 11 cycles, next o_word_start delayed by 1.
REQ-034 Accept at the load cycle with hold empty (bypass) -> word starts next cycle, o_underrun=0; accept with hold full at load -> old word sent, new word held, full stays 1.
REQ-035 Assert i_rst_n low at cnt=6 with hold full -> all outputs 0 asynchronously; after release, idle pattern starts after 10 cycles, held word never emitted.
